// File: rtl/r2s_frame_monitor.sv
// r2s_frame_monitor: tracks rows within a frame from the R2S and FSYNC strobes in the
// CLK_320 domain. It checks the R2S period and the row count per frame, and produces
// a row-windowed start pulse for the DCD data pulser.
module r2s_frame_monitor #(
    parameter int PERIOD_WIDTH = 16,
    parameter int ROW_WIDTH    = 10,
    parameter int FRAME_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    R2S_STROBE,
    input  logic                    FSYNC_STROBE,
    input  logic [PERIOD_WIDTH-1:0] EXP_PERIOD,
    input  logic [7:0]              PERIOD_TOL,
    input  logic [ROW_WIDTH-1:0]    EXP_ROWS,
    input  logic [ROW_WIDTH-1:0]    ROW_FIRST,
    input  logic [ROW_WIDTH-1:0]    ROW_LAST,
    input  logic                    CLEAR_ERR,
    output logic                    SYNCED,
    output logic                    ROW_START,
    output logic [ROW_WIDTH-1:0]    ROW_CNT,
    output logic [FRAME_WIDTH-1:0]  FRAME_CNT,
    output logic [PERIOD_WIDTH-1:0] LAST_PERIOD,
    output logic                    PERIOD_ERR,
    output logic                    ROWS_ERR,
    output logic [7:0]              ERR_CNT
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FSYNC = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] pcnt;

    logic                    run_r2s;
    logic                    run_fsync;
    logic                    pcnt_sat;
    logic [PERIOD_WIDTH:0]   period_diff;
    logic [PERIOD_WIDTH:0]   period_abs;
    logic [PERIOD_WIDTH:0]   tol_ext;
    logic                    period_event;
    logic                    rows_event;
    logic [1:0]              event_cnt;
    logic [8:0]              err_sum;
    logic [7:0]              err_next;
    logic [ROW_WIDTH-1:0]    row_idx;
    logic [ROW_WIDTH-1:0]    row_inc;
    logic                    row_in_window;

    // Decode strobes in RUN and work out error events, the row index and the next counter values.
    // FSYNC takes priority: when it coincides with an R2S, that R2S becomes row 0 of the new frame.
    always_comb begin
        run_r2s       = 1'b0;
        run_fsync     = 1'b0;
        pcnt_sat      = 1'b0;
        period_diff   = '0;
        period_abs    = '0;
        tol_ext       = '0;
        period_event  = 1'b0;
        rows_event    = 1'b0;
        event_cnt     = 2'd0;
        err_sum       = 9'd0;
        err_next      = 8'd0;
        row_idx       = '0;
        row_inc       = '0;
        row_in_window = 1'b0;

        run_r2s   = (state == RUN) && EN && R2S_STROBE;
        run_fsync = (state == RUN) && EN && FSYNC_STROBE;
        pcnt_sat  = &pcnt;

        period_diff = {1'b0, pcnt} - {1'b0, EXP_PERIOD};
        period_abs  = period_diff[PERIOD_WIDTH] ? (~period_diff + 1'b1) : period_diff;
        tol_ext     = {{(PERIOD_WIDTH - 7){1'b0}}, PERIOD_TOL};

        period_event = run_r2s && !run_fsync && (ROW_CNT != '0) && (EXP_PERIOD != '0) &&
                       ((period_abs > tol_ext) || pcnt_sat);
        rows_event   = run_fsync && (EXP_ROWS != '0) && (ROW_CNT != EXP_ROWS);

        event_cnt = {1'b0, period_event} + {1'b0, rows_event};
        err_sum   = {1'b0, ERR_CNT} + {7'b0, event_cnt};
        err_next  = err_sum[8] ? 8'hFF : err_sum[7:0];

        row_idx       = run_fsync ? '0 : ROW_CNT;
        row_inc       = (&row_idx) ? row_idx : row_idx + 1'b1;
        row_in_window = (row_idx >= ROW_FIRST) && (row_idx <= ROW_LAST);
    end

    // Monitor state machine, counters, window pulse and sticky error bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            pcnt        <= '0;
            SYNCED      <= 1'b0;
            ROW_START   <= 1'b0;
            ROW_CNT     <= '0;
            FRAME_CNT   <= '0;
            LAST_PERIOD <= '0;
            PERIOD_ERR  <= 1'b0;
            ROWS_ERR    <= 1'b0;
            ERR_CNT     <= '0;
        end else begin
            ROW_START <= 1'b0;

            if (CLEAR_ERR) begin
                PERIOD_ERR <= period_event;
                ROWS_ERR   <= rows_event;
                ERR_CNT    <= {6'b0, event_cnt};
            end else begin
                if (period_event) begin
                    PERIOD_ERR <= 1'b1;
                end
                if (rows_event) begin
                    ROWS_ERR <= 1'b1;
                end
                ERR_CNT <= err_next;
            end

            if (!EN) begin
                state  <= IDLE;
                SYNCED <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_FSYNC;
                    end
                    WAIT_FSYNC: begin
                        if (FSYNC_STROBE) begin
                            state   <= RUN;
                            SYNCED  <= 1'b1;
                            ROW_CNT <= '0;
                            pcnt    <= {{(PERIOD_WIDTH - 1){1'b0}}, 1'b1};
                        end
                    end
                    RUN: begin
                        if (R2S_STROBE || FSYNC_STROBE) begin
                            pcnt <= {{(PERIOD_WIDTH - 1){1'b0}}, 1'b1};
                        end else if (!pcnt_sat) begin
                            pcnt <= pcnt + 1'b1;
                        end

                        if (FSYNC_STROBE) begin
                            FRAME_CNT <= FRAME_CNT + 1'b1;
                            ROW_CNT   <= '0;
                        end

                        if (R2S_STROBE) begin
                            ROW_CNT   <= row_inc;
                            ROW_START <= row_in_window;
                            if (!FSYNC_STROBE && (ROW_CNT != '0)) begin
                                LAST_PERIOD <= pcnt;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        SYNCED <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
